// File: rtl/udar_link_pkg.sv
// Shared constants, state encoding and checksum helper for the servo link controller.
package udar_link_pkg;

  localparam logic [7:0] HDR_CMD  = 8'hF0;
  localparam logic [7:0] HDR_SRST = 8'h00;
  localparam logic [7:0] HDR_RSP  = 8'h0F;
  localparam logic [7:0] HDR_NAK  = 8'hEE;

  localparam int unsigned ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = 4'd0,
    S_RD_POS  = 4'd1,
    S_RD_SUM  = 4'd2,
    S_SETTLE  = 4'd3,
    S_MEAS    = 4'd4,
    S_TX_SEND = 4'd5,
    S_TX_HI   = 4'd6,
    S_TX_LO   = 4'd7,
    S_SRST    = 4'd8
  } state_t;

  // Running frame checksum: plain 8-bit add, carries discarded.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Load / count-down cycle timer; done while the count sits at zero.
module cyc_timer #(
  parameter int unsigned CNT_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [CNT_LEN-1:0] i_val,
  output logic               o_done_c
);

  logic [CNT_LEN-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_LEN'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/servo_link_ctrl.sv
// Host frame parser, servo position bus, settle/measure sequencing and response transmitter.
module servo_link_ctrl
  import udar_link_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned HOME       = 150,
  parameter int unsigned LEN_BYTES  = 2,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned SRST_CYC   = 500,
  parameter int unsigned RX_TO      = 50000,
  parameter int unsigned CNT_LEN    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  output logic [7:0]             tx_data,
  output logic                   tx_send,
  input  logic                   tx_busy,
  output logic [NCH*8-1:0]       pos,
  output logic                   meas_en,
  input  logic                   meas_done,
  input  logic [LEN_BYTES*8-1:0] meas_len,
  output logic                   soft_rst,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned CH_W  = $clog2(NCH + 1);
  localparam int unsigned TX_W  = $clog2(LEN_BYTES + 3);
  localparam int unsigned POS_W = NCH * 8;
  localparam int unsigned RSP_W = (LEN_BYTES + 2) * 8;
  localparam logic [7:0]       HOME_B   = 8'(HOME);
  localparam logic [POS_W-1:0] HOME_VEC = {NCH{HOME_B}};

  state_t             r_state;
  logic [CH_W-1:0]    r_ch_idx;
  logic [7:0]         r_sum;
  logic [POS_W-1:0]   r_shadow;
  logic [POS_W-1:0]   r_pos;
  logic [RSP_W-1:0]   r_resp;
  logic [TX_W-1:0]    r_tx_idx;
  logic [TX_W-1:0]    r_tx_last;
  logic [7:0]         r_tx_data;
  logic               r_tx_send;
  logic               r_meas_en;
  logic               r_soft_rst;
  logic               r_frame_err;
  logic               r_busy;

  logic [7:0]         w_len_sum;
  logic               w_sum_ok;
  logic               w_tmr_load;
  logic [CNT_LEN-1:0] w_tmr_val;
  logic               w_tmr_done;

  // Checksum of the measurement result bytes for the response trailer.
  always_comb begin
    w_len_sum = '0;
    for (int i = 0; i < int'(LEN_BYTES); i++) begin
      w_len_sum = csum_add(w_len_sum, meas_len[i*8 +: 8]);
    end
  end

  assign w_sum_ok = (rx_data == r_sum);

  // Every state that uses the timer is entered on an accepted byte, so reload on those bytes.
  assign w_tmr_load = rx_done &&
                      (r_state == S_IDLE || r_state == S_RD_POS || r_state == S_RD_SUM);

  // Pick the reload value for the state about to be entered; default is the inter-byte timeout.
  always_comb begin
    w_tmr_val = CNT_LEN'(RX_TO - 1);
    if (r_state == S_RD_SUM && w_sum_ok) begin
      w_tmr_val = CNT_LEN'(SETTLE_CYC - 1);
    end else if (r_state == S_IDLE && rx_data == HDR_SRST) begin
      w_tmr_val = CNT_LEN'(SRST_CYC - 1);
    end
  end

  cyc_timer #(
    .CNT_LEN (CNT_LEN)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_tmr_load),
    .i_val    (w_tmr_val),
    .o_done_c (w_tmr_done)
  );

  // Link controller FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_idx    <= '0;
      r_sum       <= '0;
      r_shadow    <= '0;
      r_pos       <= HOME_VEC;
      r_resp      <= '0;
      r_tx_idx    <= '0;
      r_tx_last   <= '0;
      r_tx_data   <= '0;
      r_tx_send   <= 1'b0;
      r_meas_en   <= 1'b0;
      r_soft_rst  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tx_send   <= 1'b0;
      r_meas_en   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_done) begin
            if (rx_data == HDR_CMD) begin
              r_ch_idx <= '0;
              r_sum    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_RD_POS;
            end else if (rx_data == HDR_SRST) begin
              r_soft_rst <= 1'b1;
              r_pos      <= HOME_VEC;
              r_busy     <= 1'b1;
              r_state    <= S_SRST;
            end
          end
        end
        S_RD_POS: begin
          if (rx_done) begin
            r_shadow[int'(r_ch_idx)*8 +: 8] <= rx_data;
            r_sum <= csum_add(r_sum, rx_data);
            if (r_ch_idx == CH_W'(NCH - 1)) begin
              r_state <= S_RD_SUM;
            end else begin
              r_ch_idx <= r_ch_idx + CH_W'(1);
            end
          end else if (w_tmr_done) begin
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_RD_SUM: begin
          if (rx_done) begin
            if (w_sum_ok) begin
              r_pos   <= r_shadow;
              r_state <= S_SETTLE;
            end else begin
              r_frame_err  <= 1'b1;
              r_resp[7:0]  <= HDR_NAK;
              r_tx_idx     <= '0;
              r_tx_last    <= '0;
              r_state      <= S_TX_SEND;
            end
          end else if (w_tmr_done) begin
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (w_tmr_done) begin
            r_meas_en <= 1'b1;
            r_state   <= S_MEAS;
          end
        end
        S_MEAS: begin
          if (meas_done) begin
            r_resp[7:0] <= HDR_RSP;
            for (int i = 0; i < int'(LEN_BYTES); i++) begin
              r_resp[(i+1)*8 +: 8] <= meas_len[(int'(LEN_BYTES)-1-i)*8 +: 8];
            end
            r_resp[(LEN_BYTES+1)*8 +: 8] <= w_len_sum;
            r_tx_idx  <= '0;
            r_tx_last <= TX_W'(LEN_BYTES + 1);
            r_state   <= S_TX_SEND;
          end
        end
        S_TX_SEND: begin
          if (!tx_busy) begin
            r_tx_data <= r_resp[int'(r_tx_idx)*8 +: 8];
            r_tx_send <= 1'b1;
            r_state   <= S_TX_HI;
          end
        end
        S_TX_HI: begin
          if (tx_busy) begin
            r_state <= S_TX_LO;
          end
        end
        S_TX_LO: begin
          if (!tx_busy) begin
            if (r_tx_idx == r_tx_last) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + TX_W'(1);
              r_state  <= S_TX_SEND;
            end
          end
        end
        S_SRST: begin
          r_pos <= HOME_VEC;
          if (w_tmr_done) begin
            r_soft_rst <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_send   = r_tx_send;
  assign pos       = r_pos;
  assign meas_en   = r_meas_en;
  assign soft_rst  = r_soft_rst;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_servo_link_ctrl.sv
// Scoreboard bench for servo_link_ctrl: two instances (2ch/2B and 4ch/3B).
module tb_servo_link_ctrl;

  localparam int A_SETTLE = 20;
  localparam int A_SRST   = 15;
  localparam int A_RXTO   = 60;
  localparam int B_SETTLE = 30;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  rx_data_a, tx_data_a;
  logic        rx_done_a, tx_send_a, tx_busy_a, meas_en_a, meas_done_a;
  logic        soft_rst_a, frame_err_a, busy_a;
  logic [15:0] pos_a, meas_len_a;
  int          txc_a;

  logic [7:0]  rx_data_b, tx_data_b;
  logic        rx_done_b, tx_send_b, tx_busy_b, meas_en_b, meas_done_b;
  logic        soft_rst_b, frame_err_b, busy_b;
  logic [31:0] pos_b;
  logic [23:0] meas_len_b;
  int          txc_b;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] exp_a, exp_b;
  int n_tx_a = 0;
  int n_tx_b = 0;
  int n_checks = 0;
  int n_err = 0;

  servo_link_ctrl #(
    .NCH(2), .HOME(150), .LEN_BYTES(2), .SETTLE_CYC(A_SETTLE),
    .SRST_CYC(A_SRST), .RX_TO(A_RXTO), .CNT_LEN(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_done(rx_done_a),
    .tx_data(tx_data_a), .tx_send(tx_send_a), .tx_busy(tx_busy_a),
    .pos(pos_a), .meas_en(meas_en_a), .meas_done(meas_done_a),
    .meas_len(meas_len_a), .soft_rst(soft_rst_a), .frame_err(frame_err_a),
    .busy(busy_a)
  );

  servo_link_ctrl #(
    .NCH(4), .HOME(150), .LEN_BYTES(3), .SETTLE_CYC(B_SETTLE),
    .SRST_CYC(10), .RX_TO(80), .CNT_LEN(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_done(rx_done_b),
    .tx_data(tx_data_b), .tx_send(tx_send_b), .tx_busy(tx_busy_b),
    .pos(pos_b), .meas_en(meas_en_b), .meas_done(meas_done_b),
    .meas_len(meas_len_b), .soft_rst(soft_rst_b), .frame_err(frame_err_b),
    .busy(busy_b)
  );

  always #10 clk = ~clk;

  // Transmitter models: busy for 10 cycles per byte.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy_a <= 1'b0;
      txc_a     <= 0;
    end else if (tx_send_a) begin
      tx_busy_a <= 1'b1;
      txc_a     <= 9;
    end else if (txc_a != 0) begin
      txc_a <= txc_a - 1;
    end else begin
      tx_busy_a <= 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy_b <= 1'b0;
      txc_b     <= 0;
    end else if (tx_send_b) begin
      tx_busy_b <= 1'b1;
      txc_b     <= 9;
    end else if (txc_b != 0) begin
      txc_b <= txc_b - 1;
    end else begin
      tx_busy_b <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Monitor: every tx_send pops the next expected byte.
  always @(negedge clk) begin
    if (tx_send_a) begin
      n_tx_a++;
      chk("a_busy_at_send", tx_busy_a, 0);
      if (q_a.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL a_tx_unexpected: got %02h required none", tx_data_a);
      end else begin
        exp_a = q_a.pop_front();
        chk("a_tx_byte", tx_data_a, exp_a);
      end
    end
    if (tx_send_b) begin
      n_tx_b++;
      chk("b_busy_at_send", tx_busy_b, 0);
      if (q_b.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL b_tx_unexpected: got %02h required none", tx_data_b);
      end else begin
        exp_b = q_b.pop_front();
        chk("b_tx_byte", tx_data_b, exp_b);
      end
    end
  end

  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    rx_data_a = b;
    rx_done_a = 1'b1;
    @(negedge clk);
    rx_done_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    rx_data_b = b;
    rx_done_b = 1'b1;
    @(negedge clk);
    rx_done_b = 1'b0;
  endtask

  task automatic wait_meas_a(input int k0, input int exp, input string nm);
    int k;
    k = k0;
    while (!meas_en_a && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, k, exp);
  endtask

  task automatic wait_meas_b(input int k0, input int exp, input string nm);
    int k;
    k = k0;
    while (!meas_en_b && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, k, exp);
  endtask

  task automatic meas_a(input logic [15:0] v);
    @(negedge clk);
    chk("a_meas_en_pulse", meas_en_a, 0);
    meas_done_a = 1'b1;
    meas_len_a  = v;
    @(negedge clk);
    meas_done_a = 1'b0;
    @(negedge clk);
    chk("a_first_send_latency", tx_send_a, 1);
  endtask

  task automatic meas_b(input logic [23:0] v);
    @(negedge clk);
    chk("b_meas_en_pulse", meas_en_b, 0);
    meas_done_b = 1'b1;
    meas_len_b  = v;
    @(negedge clk);
    meas_done_b = 1'b0;
    @(negedge clk);
    chk("b_first_send_latency", tx_send_b, 1);
  endtask

  task automatic idle_a(input string nm);
    int k;
    k = 0;
    while ((busy_a || tx_busy_a) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_busy"}, busy_a, 0);
    chk({nm, "_queue_left"}, q_a.size(), 0);
  endtask

  task automatic idle_b(input string nm);
    int k;
    k = 0;
    while ((busy_b || tx_busy_b) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_busy"}, busy_b, 0);
    chk({nm, "_queue_left"}, q_b.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    rst = 1'b1;
    rx_data_a = '0; rx_done_a = 1'b0; meas_done_a = 1'b0; meas_len_a = '0;
    rx_data_b = '0; rx_done_b = 1'b0; meas_done_b = 1'b0; meas_len_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_pos_a", pos_a, 16'h9696);
    chk("rst_pos_b", pos_b, 32'h96969696);
    chk("rst_outs_a", {tx_data_a, tx_send_a, meas_en_a, soft_rst_a, frame_err_a, busy_a}, 0);

    // Valid frame F0 64 C8 2C
    send_a(8'hF0); send_a(8'h64); send_a(8'hC8);
    chk("t1_pos_before_sum", pos_a, 16'h9696);
    send_a(8'h2C);
    chk("t1_pos", pos_a, 16'hC864);
    chk("t1_busy", busy_a, 1);
    wait_meas_a(0, A_SETTLE, "t1_settle_cycles");
    q_a.push_back(8'h0F); q_a.push_back(8'h12); q_a.push_back(8'h34); q_a.push_back(8'h46);
    meas_a(16'h1234);
    idle_a("t1");

    // Soft reset after a valid frame
    send_a(8'h00);
    chk("t4_pos_home", pos_a, 16'h9696);
    k = 0;
    while (soft_rst_a && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("t4_srst_cycles", k, A_SRST);
    chk("t4_busy_after", busy_a, 0);
    chk("t4_pos_after", pos_a, 16'h9696);

    // Bad checksum: NAK only, pos unchanged
    q_a.push_back(8'hEE);
    send_a(8'hF0); send_a(8'h64); send_a(8'hC8); send_a(8'h00);
    chk("t2_frame_err", frame_err_a, 1);
    chk("t2_pos", pos_a, 16'h9696);
    @(negedge clk);
    chk("t2_frame_err_pulse", frame_err_a, 0);
    idle_a("t2");

    // Inter-byte timeout, then a fresh frame with a byte injected during settle
    send_a(8'hF0); send_a(8'h64);
    k = 0;
    while (!frame_err_a && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t3_timeout_cycles", k, A_RXTO);
    chk("t3_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    send_a(8'hF0); send_a(8'h0A); send_a(8'h14); send_a(8'h1E);
    chk("t3_pos", pos_a, 16'h140A);
    send_a(8'h00);
    wait_meas_a(2, A_SETTLE, "t3_settle_cycles");
    chk("t3_no_srst", soft_rst_a, 0);
    q_a.push_back(8'h0F); q_a.push_back(8'hAB); q_a.push_back(8'hCD); q_a.push_back(8'h78);
    meas_a(16'hABCD);
    idle_a("t3");

    // Reset during the second response byte
    base = n_tx_a;
    send_a(8'hF0); send_a(8'h01); send_a(8'h02); send_a(8'h03);
    chk("t5_pos", pos_a, 16'h0201);
    wait_meas_a(0, A_SETTLE, "t5_settle_cycles");
    q_a.push_back(8'h0F); q_a.push_back(8'h56);
    meas_a(16'h5678);
    k = 0;
    while (n_tx_a < base + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t5_two_sends", n_tx_a, base + 2);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_pos", pos_a, 16'h9696);
    chk("t5_rst_outs", {tx_data_a, tx_send_a, meas_en_a, soft_rst_a, frame_err_a, busy_a}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_no_more_sends", n_tx_a, base + 2);
    chk("t5_busy", busy_a, 0);
    chk("t5_queue_left", q_a.size(), 0);

    // 4 channels, 3-byte result, bytes injected during settle
    send_b(8'hF0); send_b(8'h10); send_b(8'h20); send_b(8'h30); send_b(8'h40); send_b(8'hA0);
    chk("b_pos", pos_b, 32'h40302010);
    send_b(8'hF0); send_b(8'h00); send_b(8'h55);
    wait_meas_b(6, B_SETTLE, "b_settle_cycles");
    chk("b_pos_kept", pos_b, 32'h40302010);
    chk("b_no_srst", soft_rst_b, 0);
    q_b.push_back(8'h0F); q_b.push_back(8'h01); q_b.push_back(8'h02);
    q_b.push_back(8'hFF); q_b.push_back(8'h02);
    meas_b(24'h0102FF);
    idle_b("b");
    chk("b_byte_count", n_tx_b, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
